// File: rtl/dv_scoreboard.sv
// dv_scoreboard: in-order checker of the DUT output stream against an expected-packet
// FIFO, with error accounting, random backpressure and drain-phase completion.
//
// state   | meaning
// S_IDLE  | waiting for start; packets are still checked
// S_RUN   | checking while the driver is still producing
// S_DRAIN | driver finished; waiting for FIFO to empty or drain timer to expire
// S_DONE  | check complete; held until reset
module dv_scoreboard #(
    parameter int              AW            = 32,
    parameter int              PW            = 2*AW+40,
    parameter int              DEPTH         = 16,
    parameter logic [PW-1:0]   CMP_MASK      = '1,
    parameter bit              WAIT_EN       = 1'b0,
    parameter logic [15:0]     SEED          = 16'hACE1,
    parameter int              DRAIN_TIMEOUT = 1000,
    parameter int              CW            = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stim_done,
    input  logic          exp_access,
    input  logic [PW-1:0] exp_packet,
    output logic          exp_wait,
    input  logic          dut_access,
    input  logic [PW-1:0] dut_packet,
    output logic          dut_wait,
    output logic          test_done,
    output logic          test_fail,
    output logic [CW-1:0] match_count,
    output logic [CW-1:0] error_count,
    output logic [PW-1:0] first_err_packet
);
    localparam int           PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [31:0]  TIMER_LOAD = 32'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [31:0]         timer_q, timer_d;
    logic                dut_wait_q, dut_wait_d;
    logic                test_done_q, test_done_d;
    logic                test_fail_q, test_fail_d;
    logic [CW-1:0]       match_q, match_d;
    logic [CW-1:0]       error_q, error_d;
    logic [PW-1:0]       first_err_q, first_err_d;
    logic                err_seen_q, err_seen_d;

    logic                push, overflow, accept, fifo_empty, pop;
    logic                pkt_equal, match_hit, dut_err, timeout_err;
    logic [1:0]          err_inc;
    logic [CW+1:0]       err_sum;

    assign exp_wait   = (count_q == FULL_CNT);
    assign push       = exp_access & ~exp_wait;
    assign overflow   = exp_access & exp_wait;
    assign accept     = dut_access & ~dut_wait_q;
    assign fifo_empty = (count_q == '0);
    // Packets arriving after completion are never compared, only counted as errors.
    assign pop        = accept & ~fifo_empty & (state_q != S_DONE);
    assign pkt_equal  = (((fifo_mem[rd_ptr_q] ^ dut_packet) & CMP_MASK) == '0);
    assign match_hit  = pop & pkt_equal;
    assign dut_err    = accept & ~match_hit;

    always_comb begin
        state_d     = state_q;
        timer_d     = TIMER_LOAD;
        timeout_err = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (stim_done) state_d = S_DRAIN;
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_DONE;
                end else if (timer_q == '0) begin
                    state_d     = S_DONE;
                    timeout_err = 1'b1;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            default: state_d = S_DONE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        err_inc = {1'b0, overflow} + {1'b0, dut_err} + {1'b0, timeout_err};
        err_sum = {2'b00, error_q} + (CW+2)'(err_inc);
        error_d = (err_sum[CW+1:CW] != 2'b00) ? '1 : err_sum[CW-1:0];
        match_d = (match_hit && (match_q != '1)) ? match_q + CW'(1) : match_q;

        test_fail_d = test_fail_q | (err_inc != 2'b00);
        first_err_d = first_err_q;
        err_seen_d  = err_seen_q;
        if (dut_err && !err_seen_q) begin
            first_err_d = dut_packet;
            err_seen_d  = 1'b1;
        end

        lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        dut_wait_d  = WAIT_EN && ((state_q == S_RUN) || (state_q == S_DRAIN)) ? lfsr_q[0] : 1'b0;
        test_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lfsr_q      <= SEED;
            timer_q     <= TIMER_LOAD;
            dut_wait_q  <= 1'b0;
            test_done_q <= 1'b0;
            test_fail_q <= 1'b0;
            match_q     <= '0;
            error_q     <= '0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lfsr_q      <= lfsr_d;
            timer_q     <= timer_d;
            dut_wait_q  <= dut_wait_d;
            test_done_q <= test_done_d;
            test_fail_q <= test_fail_d;
            match_q     <= match_d;
            error_q     <= error_d;
            first_err_q <= first_err_d;
            err_seen_q  <= err_seen_d;
        end
    end

    // Storage needs no reset: the pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= exp_packet;
    end

    assign dut_wait         = dut_wait_q;
    assign test_done        = test_done_q;
    assign test_fail        = test_fail_q;
    assign match_count      = match_q;
    assign error_count      = error_q;
    assign first_err_packet = first_err_q;

endmodule

// File: tb/tb_dv_scoreboard.sv
// Self-checking bench for dv_scoreboard: instance a has no backpressure and a short
// drain timeout, instance b has LFSR backpressure for the long streaming run.
module tb_dv_scoreboard;
    localparam int            AW    = 32;
    localparam int            PW    = 2*AW+40;
    localparam int            DEPTH = 16;
    localparam int            CW    = 32;
    localparam logic [PW-1:0] MASK  = {{(PW-8){1'b1}}, 8'h00};
    localparam logic [15:0]   SEED  = 16'hACE1;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, stim_done = 1'b0;
    logic exp_access = 1'b0, dut_access = 1'b0;
    logic [PW-1:0] exp_packet = '0, dut_packet = '0;

    logic a_exp_wait, a_dut_wait, a_test_done, a_test_fail;
    logic b_exp_wait, b_dut_wait, b_test_done, b_test_fail;
    logic [CW-1:0] a_match, a_error, b_match, b_error;
    logic [PW-1:0] a_first, b_first;

    bit sel_b = 1'b0;
    logic o_exp_wait, o_dut_wait, o_test_done, o_test_fail;
    logic [CW-1:0] o_match, o_error;
    logic [PW-1:0] o_first;
    assign o_exp_wait  = sel_b ? b_exp_wait  : a_exp_wait;
    assign o_dut_wait  = sel_b ? b_dut_wait  : a_dut_wait;
    assign o_test_done = sel_b ? b_test_done : a_test_done;
    assign o_test_fail = sel_b ? b_test_fail : a_test_fail;
    assign o_match     = sel_b ? b_match     : a_match;
    assign o_error     = sel_b ? b_error     : a_error;
    assign o_first     = sel_b ? b_first     : a_first;

    always #5 clk = ~clk;

    dv_scoreboard #(.AW(AW), .DEPTH(DEPTH), .CMP_MASK(MASK), .WAIT_EN(1'b0), .SEED(SEED),
                    .DRAIN_TIMEOUT(10), .CW(CW)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .stim_done(stim_done),
        .exp_access(exp_access), .exp_packet(exp_packet), .exp_wait(a_exp_wait),
        .dut_access(dut_access), .dut_packet(dut_packet), .dut_wait(a_dut_wait),
        .test_done(a_test_done), .test_fail(a_test_fail), .match_count(a_match),
        .error_count(a_error), .first_err_packet(a_first));

    dv_scoreboard #(.AW(AW), .DEPTH(DEPTH), .CMP_MASK(MASK), .WAIT_EN(1'b1), .SEED(SEED),
                    .DRAIN_TIMEOUT(1000), .CW(CW)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .stim_done(stim_done),
        .exp_access(exp_access), .exp_packet(exp_packet), .exp_wait(b_exp_wait),
        .dut_access(dut_access), .dut_packet(dut_packet), .dut_wait(b_dut_wait),
        .test_done(b_test_done), .test_fail(b_test_fail), .match_count(b_match),
        .error_count(b_error), .first_err_packet(b_first));

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] sbq[$];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] pk(input int i);
        logic [31:0] v;
        v = i;
        return {v * 32'h9E37_79B9, ~v, v[7:0] ^ 8'hC3, 32'h5A00_0000 | v};
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stim_done = 1'b0;
        exp_access = 1'b0; dut_access = 1'b0;
        sbq.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference LFSR for instance b's backpressure; dut_wait lags the register by one cycle.
    bit chk_wait = 1'b0;
    logic [15:0] lf_m = SEED;
    logic lf_prev0, td_before, lf_fb;
    int w_hi = 0, w_lo = 0;
    always @(posedge clk) begin
        lf_prev0  = lf_m[0];
        td_before = b_test_done;
        lf_fb     = lf_m[0] ^ lf_m[2] ^ lf_m[3] ^ lf_m[5];
        if (reset) lf_m = SEED;
        else       lf_m = (lf_m >> 1) | (16'(lf_fb) << 15);
        #1;
        if (chk_wait && !td_before) begin
            check("dut_wait_lfsr", b_dut_wait, lf_prev0);
            if (b_dut_wait) w_hi++; else w_lo++;
        end
    end

    // Producer pushes to the bench queue once the DUT has taken the packet; consumer
    // replays queue entries to the DUT side and holds each until accepted.
    task automatic run_stream(input int n, input int dly);
        int pi, pb, acc, cb, wcnt, db;
        logic wc;
        do_reset();
        start = 1'b1; tick();
        start = 1'b0; tick();
        if (sel_b) chk_wait = 1'b1;
        pi = 0; pb = 0; acc = 0; cb = 0; wcnt = 0;
        fork
            begin
                while (pi < n && pb < 5000) begin
                    if (o_exp_wait) begin
                        exp_access = 1'b0;
                        tick();
                    end else begin
                        exp_access = 1'b1;
                        exp_packet = pk(pi);
                        tick();
                        sbq.push_back(pk(pi));
                        pi++;
                    end
                    pb++;
                end
                exp_access = 1'b0;
                stim_done  = 1'b1;
            end
            begin
                repeat (dly) tick();
                while (acc < n && cb < 5000) begin
                    if (!dut_access && sbq.size() > 0) begin
                        dut_packet = sbq.pop_front();
                        dut_access = 1'b1;
                    end
                    wc = o_dut_wait;
                    if (wc) wcnt++;
                    tick();
                    cb++;
                    if (dut_access && !wc) begin
                        acc++;
                        dut_access = 1'b0;
                    end
                end
                dut_access = 1'b0;
            end
        join
        db = 0;
        while (!o_test_done && db < 200) begin
            tick();
            db++;
        end
        chk_wait = 1'b0;
        check("stream_pushed", pi, n);
        check("stream_accepted", acc, n);
        check("stream_done", o_test_done, 1);
        check("stream_match", o_match, n);
        check("stream_error", o_error, 0);
        check("stream_fail", o_test_fail, 0);
        check("stream_exp_wait", o_exp_wait, 0);
        check("stream_leftover", sbq.size(), 0);
        if (sel_b) check("stream_wait_toggles", (w_hi > 0) && (w_lo > 0), 1);
        else       check("stream_no_backpressure", wcnt, 0);
        stim_done = 1'b0;
    endtask

    typedef struct {
        logic          ea;
        logic [PW-1:0] ep;
        logic          da;
        logic [PW-1:0] dp;
        int            m;
        int            e;
        logic          f;
        logic          ew;
    } vec_t;

    initial begin
        vec_t tbl[6];
        logic [PW-1:0] pa, pb_, pc, px, pcm, py, pd;

        #500000;
        $display("FAIL watchdog: got time limit expected self-termination");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        logic [PW-1:0] pa, pb_, pc, px, pcm, py, pd;

        pa  = pk(1);
        pb_ = pk(2);
        pc  = pk(3);
        px  = pb_ ^ (PW'(1) << 50);
        pcm = pc ^ PW'(8'h5A);
        py  = pk(9);
        pd  = pk(4);
        tbl[0] = '{1'b1, pa,  1'b0, '0,  0, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, pb_, 1'b1, pa,  1, 0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, pc,  1'b1, px,  1, 1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, '0,  1'b1, pcm, 2, 1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, pd,  1'b1, py,  2, 2, 1'b1, 1'b0};
        tbl[5] = '{1'b0, '0,  1'b1, pd,  3, 2, 1'b1, 1'b0};

        // Reset values on both instances
        tick();
        tick();
        check("rst_exp_wait", a_exp_wait, 0);
        check("rst_dut_wait", a_dut_wait, 0);
        check("rst_done", a_test_done, 0);
        check("rst_fail", a_test_fail, 0);
        check("rst_match", a_match, 0);
        check("rst_error", a_error, 0);
        check("rst_first", a_first, 0);
        check("rst_b_dut_wait", b_dut_wait, 0);
        reset = 1'b0;

        // Compare table in IDLE: mismatch, masked-bit tolerance, unexpected with push
        for (int r = 0; r < 6; r++) begin
            exp_access = tbl[r].ea; exp_packet = tbl[r].ep;
            dut_access = tbl[r].da; dut_packet = tbl[r].dp;
            tick();
            check($sformatf("tbl%0d_match", r), o_match, tbl[r].m);
            check($sformatf("tbl%0d_error", r), o_error, tbl[r].e);
            check($sformatf("tbl%0d_fail", r), o_test_fail, tbl[r].f);
            check($sformatf("tbl%0d_exp_wait", r), o_exp_wait, tbl[r].ew);
        end
        exp_access = 1'b0; dut_access = 1'b0;
        check("tbl_first_err", o_first, px);

        // Unexpected DUT packet in the same cycle as the first push
        do_reset();
        exp_access = 1'b1; exp_packet = pk(30);
        dut_access = 1'b1; dut_packet = pk(31);
        tick();
        exp_access = 1'b0; dut_access = 1'b0;
        check("unexp_error", o_error, 1);
        check("unexp_first", o_first, pk(31));
        check("unexp_fail", o_test_fail, 1);
        dut_access = 1'b1; dut_packet = pk(30);
        tick();
        dut_access = 1'b0;
        check("unexp_retained_match", o_match, 1);
        check("unexp_retained_error", o_error, 1);

        // Fill to DEPTH, then overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            exp_access = 1'b1; exp_packet = pk(20 + i);
            tick();
            check($sformatf("fill%0d_exp_wait", i), o_exp_wait, i == DEPTH - 1);
        end
        exp_packet = pk(99);
        tick();
        exp_access = 1'b0;
        check("ovf_error", o_error, 1);
        check("ovf_exp_wait", o_exp_wait, 1);
        check("ovf_first_untouched", o_first, 0);
        dut_access = 1'b1; dut_packet = pk(20);
        tick();
        check("ovf_pop0_match", o_match, 1);
        check("ovf_pop0_exp_wait", o_exp_wait, 0);
        dut_packet = pk(21);
        tick();
        dut_access = 1'b0;
        check("ovf_pop1_match", o_match, 2);
        check("ovf_pop1_error", o_error, 1);

        // 8 packets returned 3 cycles late, no backpressure
        sel_b = 1'b0;
        run_stream(8, 3);

        // 100-packet stream under LFSR backpressure
        sel_b = 1'b1;
        run_stream(100, 2);
        sel_b = 1'b0;

        // Drain timeout with two entries outstanding, then an extra packet in DONE
        do_reset();
        start = 1'b1; exp_access = 1'b1; exp_packet = pk(50);
        tick();
        start = 1'b0; exp_packet = pk(51); stim_done = 1'b1;
        tick();
        exp_access = 1'b0;
        repeat (9) tick();
        check("drain_done_early", o_test_done, 0);
        check("drain_error_early", o_error, 0);
        tick();
        check("drain_done", o_test_done, 1);
        check("drain_timeout_error", o_error, 1);
        check("drain_fail", o_test_fail, 1);
        check("drain_first_untouched", o_first, 0);
        dut_access = 1'b1; dut_packet = pk(50);
        tick();
        dut_access = 1'b0;
        check("extra_error", o_error, 2);
        check("extra_match", o_match, 0);
        check("extra_first", o_first, pk(50));
        check("extra_done_held", o_test_done, 1);
        stim_done = 1'b0;

        // Reset asserted mid-RUN
        do_reset();
        exp_access = 1'b1; exp_packet = pk(60);
        dut_access = 1'b1; dut_packet = pk(61);
        tick();
        exp_access = 1'b0; dut_access = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_error", o_error, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_exp_wait", o_exp_wait, 0);
        check("mid_rst_dut_wait", o_dut_wait, 0);
        check("mid_rst_done", o_test_done, 0);
        check("mid_rst_fail", o_test_fail, 0);
        check("mid_rst_match", o_match, 0);
        check("mid_rst_error", o_error, 0);
        check("mid_rst_first", o_first, 0);
        reset = 1'b0;
        exp_access = 1'b1; exp_packet = pk(62);
        tick();
        exp_access = 1'b0;
        dut_access = 1'b1; dut_packet = pk(62);
        tick();
        dut_access = 1'b0;
        check("post_rst_match", o_match, 1);
        check("post_rst_error", o_error, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
